hash_validator: RTL and testbench

HASH_VALIDATOR -- requirements
Module: hash_validator

---
 rtl/hash_validator.sv | 128 ++++++++++++
 tb/tb_hash_validator.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_validator.sv
// Checks a SHA result against a 256-bit difficulty target, one 32-bit word per cycle from MSW down.
// Optional hashCount statistics counter is enabled by defining HASH_VALIDATOR_STATS_EN.
module hash_validator (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         loadTarget,
  input  logic [255:0] targetIn,
  input  logic         complete,
  input  logic [255:0] hashIn,
  input  logic         clrResults,
  output logic         valid,
  output logic         finishedValidating,
  output logic         busy,
  output logic [255:0] resultHash
`ifdef HASH_VALIDATOR_STATS_EN
  ,
  output logic [31:0]  hashCount
`endif
);

  typedef enum logic [1:0] {IDLE, COMPARE, PASS, FAIL} state_t;

  state_t        state_reg, state_next;
  logic [255:0]  target_reg;
  logic [255:0]  hash_reg;
  logic [2:0]    idx_reg, idx_next;
  logic          hash_load;
  logic [31:0]   hash_words   [8];
  logic [31:0]   target_words [8];
  logic [31:0]   hash_word;
  logic [31:0]   target_word;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_words
      assign hash_words[gi]   = hash_reg[32*gi +: 32];
      assign target_words[gi] = target_reg[32*gi +: 32];
    end
  endgenerate

  assign hash_word   = hash_words[idx_reg];
  assign target_word = target_words[idx_reg];

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hash_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A simultaneous target load wins; the hash is dropped.
        if (complete && !loadTarget) begin
          hash_load  = 1'b1;
          idx_next   = 3'd7;
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (loadTarget)
          state_next = IDLE;
        else if (hash_word < target_word)
          state_next = PASS;
        else if (hash_word > target_word)
          state_next = FAIL;
        else if (idx_reg == 3'd0)
          state_next = PASS;
        else
          idx_next = idx_reg - 3'd1;
      end
      PASS: begin
        if (clrResults)
          state_next = IDLE;
      end
      FAIL: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg  <= IDLE;
      idx_reg    <= 3'd0;
      target_reg <= '0;
      hash_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (loadTarget)
        target_reg <= targetIn;
      if (hash_load)
        hash_reg <= hashIn;
    end
  end

  assign valid              = (state_reg == PASS);
  assign finishedValidating = (state_reg == FAIL);
  assign busy               = (state_reg == COMPARE);
  assign resultHash         = hash_reg;

`ifdef HASH_VALIDATOR_STATS_EN
  logic [31:0] count_reg, count_next;
  logic        judged;

  assign judged = (state_reg == COMPARE) &&
                  ((state_next == PASS) || (state_next == FAIL));

  // A clear coinciding with a verdict leaves that verdict counted.
  always_comb begin
    count_next = count_reg;
    if (clrResults)
      count_next = judged ? 32'd1 : 32'd0;
    else if (judged && (count_reg != 32'hFFFF_FFFF))
      count_next = count_reg + 32'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign hashCount = count_reg;
`endif

endmodule

// File: tb/tb_hash_validator.sv
// Directed self-checking bench for hash_validator; cycle 0 is the cycle in which complete is high.
// hashCount checks are compiled in only when HASH_VALIDATOR_STATS_EN is defined.
module tb_hash_validator;

  logic         clk;
  logic         n_rst;
  logic         loadTarget;
  logic [255:0] targetIn;
  logic         complete;
  logic [255:0] hashIn;
  logic         clrResults;
  logic         valid;
  logic         finishedValidating;
  logic         busy;
  logic [255:0] resultHash;
`ifdef HASH_VALIDATOR_STATS_EN
  logic [31:0]  hashCount;
`endif

  int vectors = 0;
  int errors  = 0;

  localparam logic [255:0] TGT_A  = {32'h0000FFFF, {7{32'hFFFFFFFF}}};
  localparam logic [255:0] H_PASS = {32'h00001234, 224'h0};
  localparam logic [255:0] H_FAIL = {32'h00010000, 224'h0};
  localparam logic [255:0] TGT_B  = {32'h0000FFFF, {6{32'hFFFFFFFF}}, 32'h12345678};
  localparam logic [255:0] H_B1   = {32'h0000FFFF, {6{32'hFFFFFFFF}}, 32'h12345679};
  localparam logic [255:0] TGT_C  = {32'h00001000, 224'h0};

  hash_validator dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .loadTarget         (loadTarget),
    .targetIn           (targetIn),
    .complete           (complete),
    .hashIn             (hashIn),
    .clrResults         (clrResults),
    .valid              (valid),
    .finishedValidating (finishedValidating),
    .busy               (busy),
    .resultHash         (resultHash)
`ifdef HASH_VALIDATOR_STATS_EN
    ,
    .hashCount          (hashCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_target(input logic [255:0] t);
    loadTarget = 1'b1;
    targetIn   = t;
    step();
    loadTarget = 1'b0;
  endtask

  // Leaves the bench in cycle 1.
  task automatic start_hash(input logic [255:0] h);
    complete = 1'b1;
    hashIn   = h;
    step();
    complete = 1'b0;
  endtask

  task automatic clear_pass();
    clrResults = 1'b1;
    step();
    clrResults = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    step();
    step();
    vectors++;
    if ({valid, finishedValidating, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got v/f/b=%b want 000", {valid, finishedValidating, busy});
    end
    vectors++;
    if (resultHash !== 256'h0) begin
      errors++;
      $display("FAIL reset_hash: got %h want 0", resultHash);
    end
`ifdef HASH_VALIDATOR_STATS_EN
    vectors++;
    if (hashCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", hashCount);
    end
`endif
    n_rst = 1'b1;
    step();
    $display("reset: released");
  endtask

  task automatic test_zero_target();
    start_hash(256'h0);
    for (int c = 1; c < 9; c++) begin
      vectors++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL zero_busy cycle %0d: got %b want 1", c, busy);
      end
      step();
    end
    vectors++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL zero_valid: got %b want 1", valid);
    end
    clear_pass();
    start_hash({255'h0, 1'b1});
    for (int c = 1; c < 9; c++) step();
    vectors++;
    if ({valid, finishedValidating} !== 2'b01) begin
      errors++;
      $display("FAIL zero_nonzero_hash: got v/f=%b want 01", {valid, finishedValidating});
    end
    step();
    $display("zero_target: all-zero hash passes, hash=1 fails");
  endtask

  task automatic test_pass_hold();
    load_target(TGT_A);
    start_hash(H_PASS);
    vectors++;
    if ({busy, valid} !== 2'b10) begin
      errors++;
      $display("FAIL pass_cycle1: got b/v=%b want 10", {busy, valid});
    end
    step();
    vectors++;
    if ({valid, finishedValidating, busy} !== 3'b100) begin
      errors++;
      $display("FAIL pass_cycle2: got v/f/b=%b want 100", {valid, finishedValidating, busy});
    end
    vectors++;
    if (resultHash !== H_PASS) begin
      errors++;
      $display("FAIL pass_result_hash: got %h want %h", resultHash, H_PASS);
    end
    // complete during PASS must not disturb the held result
    for (int c = 0; c < 3; c++) begin
      complete = 1'b1;
      hashIn   = H_FAIL;
      step();
      vectors++;
      if (valid !== 1'b1 || resultHash !== H_PASS) begin
        errors++;
        $display("FAIL pass_hold %0d: got valid=%b hash=%h want 1 %h", c, valid, resultHash, H_PASS);
      end
    end
    complete = 1'b0;
    clear_pass();
    vectors++;
    if ({valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL pass_cleared: got v/b=%b want 00", {valid, busy});
    end
    $display("pass_hold: valid in cycle 2, held, cleared");
  endtask

  task automatic test_fail_pulse();
    start_hash(H_FAIL);
    clrResults = 1'b1;
    step();
    clrResults = 1'b0;
    vectors++;
    if ({valid, finishedValidating, busy} !== 3'b010) begin
      errors++;
      $display("FAIL fail_cycle2: got v/f/b=%b want 010", {valid, finishedValidating, busy});
    end
`ifdef HASH_VALIDATOR_STATS_EN
    vectors++;
    if (hashCount !== 32'd1) begin
      errors++;
      $display("FAIL clear_and_count: got %0d want 1", hashCount);
    end
`endif
    step();
    vectors++;
    if ({valid, finishedValidating, busy} !== 3'b000) begin
      errors++;
      $display("FAIL fail_cycle3: got v/f/b=%b want 000", {valid, finishedValidating, busy});
    end
    $display("fail_pulse: one-cycle pulse in cycle 2");
  endtask

  task automatic test_equal();
    start_hash(TGT_A);
    for (int c = 1; c < 9; c++) begin
      vectors++;
      if ({busy, valid, finishedValidating} !== 3'b100) begin
        errors++;
        $display("FAIL equal_compare cycle %0d: got b/v/f=%b want 100", c, {busy, valid, finishedValidating});
      end
      step();
    end
    vectors++;
    if ({valid, busy} !== 2'b10) begin
      errors++;
      $display("FAIL equal_cycle9: got v/b=%b want 10", {valid, busy});
    end
    clear_pass();
    $display("equal: valid in cycle 9");
  endtask

  task automatic test_word0_over();
    load_target(TGT_B);
    start_hash(H_B1);
    for (int c = 1; c < 8; c++) step();
    vectors++;
    if ({busy, finishedValidating} !== 2'b10) begin
      errors++;
      $display("FAIL word0_cycle8: got b/f=%b want 10", {busy, finishedValidating});
    end
    step();
    vectors++;
    if ({valid, finishedValidating} !== 2'b01) begin
      errors++;
      $display("FAIL word0_cycle9: got v/f=%b want 01", {valid, finishedValidating});
    end
    step();
    $display("word0_over: pulse in cycle 9");
  endtask

  task automatic test_abort();
    load_target(TGT_A);
    start_hash(TGT_A);
    step();
    step();
    loadTarget = 1'b1;
    targetIn   = TGT_C;
    step();
    loadTarget = 1'b0;
    vectors++;
    if ({valid, finishedValidating, busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: got v/f/b=%b want 000", {valid, finishedValidating, busy});
    end
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if ({valid, finishedValidating} !== 2'b00) begin
        errors++;
        $display("FAIL abort_quiet %0d: got v/f=%b want 00", c, {valid, finishedValidating});
      end
    end
    // word7 0x1234 passes the old target but fails the new one
    start_hash(H_PASS);
    step();
    vectors++;
    if ({valid, finishedValidating} !== 2'b01) begin
      errors++;
      $display("FAIL abort_new_target: got v/f=%b want 01", {valid, finishedValidating});
    end
    step();
    $display("abort: loadTarget in COMPARE returns to IDLE");
  endtask

  task automatic test_clr_outside_pass();
    clrResults = 1'b1;
    step();
    clrResults = 1'b0;
    vectors++;
    if ({valid, finishedValidating, busy} !== 3'b000) begin
      errors++;
      $display("FAIL clr_idle: got v/f/b=%b want 000", {valid, finishedValidating, busy});
    end
    start_hash(TGT_C);
    clrResults = 1'b1;
    step();
    clrResults = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_compare: got busy=%b want 1", busy);
    end
    for (int c = 2; c < 9; c++) step();
    vectors++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_compare_result: got valid=%b want 1", valid);
    end
    clear_pass();
    $display("clr_outside_pass: no state change");
  endtask

  task automatic test_load_and_complete();
    loadTarget = 1'b1;
    targetIn   = TGT_A;
    complete   = 1'b1;
    hashIn     = H_FAIL;
    step();
    loadTarget = 1'b0;
    complete   = 1'b0;
    vectors++;
    if (busy !== 1'b0 || resultHash !== TGT_C) begin
      errors++;
      $display("FAIL load_and_complete: got busy=%b hash=%h want 0 %h", busy, resultHash, TGT_C);
    end
    start_hash(H_PASS);
    step();
    vectors++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL load_and_complete_target: got valid=%b want 1", valid);
    end
    clear_pass();
    $display("load_and_complete: complete dropped, target loaded");
  endtask

  task automatic test_reset_mid();
    start_hash(TGT_A);
    step();
    step();
    n_rst = 1'b0;
    #2;
    vectors++;
    if ({valid, finishedValidating, busy} !== 3'b000 || resultHash !== 256'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got v/f/b=%b hash=%h want 000 0", {valid, finishedValidating, busy}, resultHash);
    end
`ifdef HASH_VALIDATOR_STATS_EN
    vectors++;
    if (hashCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d want 0", hashCount);
    end
`endif
    step();
    n_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      vectors++;
      if ({valid, finishedValidating, busy} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_quiet %0d: got v/f/b=%b want 000", c, {valid, finishedValidating, busy});
      end
    end
    start_hash(256'h0);
    for (int c = 1; c < 9; c++) step();
    vectors++;
    if (valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next: got valid=%b want 1", valid);
    end
`ifdef HASH_VALIDATOR_STATS_EN
    vectors++;
    if (hashCount !== 32'd1) begin
      errors++;
      $display("FAIL reset_mid_next_count: got %0d want 1", hashCount);
    end
`endif
    clear_pass();
    $display("reset_mid: comparison discarded");
  endtask

  initial begin
    n_rst      = 1'b0;
    loadTarget = 1'b0;
    targetIn   = '0;
    complete   = 1'b0;
    hashIn     = '0;
    clrResults = 1'b0;
    test_reset();
    test_zero_target();
    test_pass_hold();
    test_fail_pulse();
    test_equal();
    test_word0_over();
    test_abort();
    test_clr_outside_pass();
    test_load_and_complete();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
